// File: rtl/stack_cmd_ctrl.sv
// Command sequencer for an attached LIFO: expands PUSH/POP/DUP/SWAP into push/pop strobes.
// Define STK_CTRL_COMPOUND_EN to build DUP/SWAP; otherwise opcodes 10/11 are rejected.
module stack_cmd_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic [CW-1:0]    occupancy
);
  localparam logic [1:0] OP_PUSH = 2'b00, OP_POP = 2'b01;
  localparam logic [3:0] S_IDLE = 4'd0, S_PUSH_D = 4'd1, S_POP_A = 4'd2, S_CAP_A = 4'd3,
                         S_PUSH_A = 4'd6, S_RESP = 4'd8;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
`ifdef STK_CTRL_COMPOUND_EN
  localparam logic [1:0] OP_DUP = 2'b10, OP_SWAP = 2'b11;
  localparam logic [3:0] S_POP_B = 4'd4, S_CAP_B = 4'd5, S_PUSH_B = 4'd7;
  localparam logic [CW-1:0] L_TWO = CW'(2);
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_b;
`endif

  logic [3:0]       r_state, w_nxt;
  logic [CW-1:0]    r_occ;
  logic [WIDTH-1:0] r_a, r_din, w_din;
  logic             r_push, r_pop, r_err;
  logic             w_legal, w_push, w_pop, w_acc;

  assign w_acc = cmd_valid && (r_state == S_IDLE);

  always_comb begin
    w_legal = 1'b0;
    case (cmd_op)
      OP_PUSH: w_legal = r_occ < L_DEPTH;
      OP_POP:  w_legal = r_occ != '0;
`ifdef STK_CTRL_COMPOUND_EN
      OP_DUP:  w_legal = (r_occ != '0) && (r_occ < L_DEPTH);
      OP_SWAP: w_legal = r_occ >= L_TWO;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  // Push data is chosen on the transition into a push state so stk_din is a flop.
  always_comb begin
    w_nxt = r_state;
    w_din = '0;
    case (r_state)
      S_IDLE: if (cmd_valid) begin
        if (!w_legal)               w_nxt = S_RESP;
        else if (cmd_op == OP_PUSH) begin w_nxt = S_PUSH_D; w_din = cmd_data; end
        else                        w_nxt = S_POP_A;
      end
      S_PUSH_D: w_nxt = S_RESP;
      S_POP_A:  w_nxt = S_CAP_A;
`ifdef STK_CTRL_COMPOUND_EN
      S_CAP_A: begin
        if (r_op == OP_POP)      w_nxt = S_RESP;
        else if (r_op == OP_DUP) begin w_nxt = S_PUSH_A; w_din = stk_dout; end
        else                     w_nxt = S_POP_B;
      end
      S_POP_B:  w_nxt = S_CAP_B;
      S_CAP_B:  begin w_nxt = S_PUSH_A; w_din = r_a; end
      S_PUSH_A: begin w_nxt = S_PUSH_B; w_din = (r_op == OP_DUP) ? r_a : r_b; end
      S_PUSH_B: w_nxt = S_RESP;
`else
      S_CAP_A:  w_nxt = S_RESP;
      S_PUSH_A: w_nxt = S_RESP;
`endif
      S_RESP:   if (rsp_ready) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
    w_push = (w_nxt == S_PUSH_D) || (w_nxt == S_PUSH_A);
    w_pop  = (w_nxt == S_POP_A);
`ifdef STK_CTRL_COMPOUND_EN
    w_push = w_push || (w_nxt == S_PUSH_B);
    w_pop  = w_pop  || (w_nxt == S_POP_B);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_occ   <= '0;
      r_a     <= '0;
      r_din   <= '0;
      r_push  <= 1'b0;
      r_pop   <= 1'b0;
      r_err   <= 1'b0;
`ifdef STK_CTRL_COMPOUND_EN
      r_op    <= '0;
      r_b     <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      r_push  <= w_push;
      r_pop   <= w_pop;
      r_din   <= w_din;
      if (r_push)     r_occ <= r_occ + CW'(1);
      else if (r_pop) r_occ <= r_occ - CW'(1);
      // A doubles as the PUSH result so rsp_data needs no extra register.
      if (w_acc) begin
        r_err <= !w_legal;
        r_a   <= (w_legal && cmd_op == OP_PUSH) ? cmd_data : '0;
`ifdef STK_CTRL_COMPOUND_EN
        r_op  <= cmd_op;
`endif
      end
      if (r_state == S_CAP_A) r_a <= stk_dout;
`ifdef STK_CTRL_COMPOUND_EN
      if (r_state == S_CAP_B) r_b <= stk_dout;
`endif
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = r_err;
  assign stk_push  = r_push;
  assign stk_pop   = r_pop;
  assign stk_din   = r_din;
  assign occupancy = r_occ;
`ifdef STK_CTRL_COMPOUND_EN
  assign rsp_data  = (r_op == OP_SWAP && !r_err) ? r_b : r_a;
`else
  assign rsp_data  = r_a;
`endif
endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Scoreboard bench for stack_cmd_ctrl with a behavioural 8-deep LIFO behind it.
module tb_stack_cmd_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0, rst = 1'b1;
  logic             cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop;
  logic [WIDTH-1:0] rsp_data, stk_din;
  logic [WIDTH-1:0] stk_dout;
  logic [CW-1:0]    occupancy;

  always #5 clk = ~clk;

  stack_cmd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_dout(stk_dout), .occupancy(occupancy)
  );

  // Attached stack: registered read port, same reset.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  int sp;
  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      stk_dout <= '0;
    end else if (stk_push) begin
      if (sp < DEPTH) mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop) begin
      if (sp > 0) stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end

  int n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0, n_both = 0;
  always @(negedge clk) begin
    if (stk_push) n_push++;
    if (stk_pop) n_pop++;
    if (stk_push && stk_pop) n_both++;
  end

  typedef struct {logic [WIDTH-1:0] data; logic err; int lat; int npush; int npop;} exp_t;
  exp_t sb[$];
  logic [WIDTH-1:0] ref_q[$];

  task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d, input int hold);
    exp_t e, g;
    int lat, p0, q0;
    int occ;
    logic [WIDTH-1:0] hd;
`ifdef STK_CTRL_COMPOUND_EN
    logic [WIDTH-1:0] a, b;
`endif
    occ = ref_q.size();
    e = '{8'h00, 1'b1, 1, 0, 0};
    case (op)
      2'b00: if (occ < DEPTH) begin e = '{d, 1'b0, 2, 1, 0}; ref_q.push_back(d); end
      2'b01: if (occ >= 1) begin e = '{ref_q.pop_back(), 1'b0, 3, 0, 1}; end
`ifdef STK_CTRL_COMPOUND_EN
      2'b10: if (occ >= 1 && occ < DEPTH) begin
        e = '{ref_q[$], 1'b0, 5, 2, 1};
        ref_q.push_back(ref_q[$]);
      end
      2'b11: if (occ >= 2) begin
        a = ref_q.pop_back(); b = ref_q.pop_back();
        ref_q.push_back(a); ref_q.push_back(b);
        e = '{b, 1'b0, 7, 2, 2};
      end
`endif
      default: ;
    endcase
    sb.push_back(e);
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_pre: got %b want 1", cmd_ready); end
    p0 = n_push; q0 = n_pop;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; rsp_ready = (hold == 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = WIDTH'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    g = sb.pop_front();
    n_cmp++;
    if (lat !== g.lat) begin n_bad++; $display("FAIL rsp_latency op=%0d: got %0d want %0d", op, lat, g.lat); end
    n_cmp++;
    if (rsp_data !== g.data) begin n_bad++; $display("FAIL rsp_data op=%0d: got %h want %h", op, rsp_data, g.data); end
    n_cmp++;
    if (rsp_err !== g.err) begin n_bad++; $display("FAIL rsp_err op=%0d: got %b want %b", op, rsp_err, g.err); end
    hd = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_err !== g.err || cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL rsp_hold cyc=%0d: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                 i, rsp_valid, rsp_data, rsp_err, cmd_ready, hd, g.err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rsp_release: got rdy=%b v=%b want rdy=1 v=0", cmd_ready, rsp_valid);
    end
    n_cmp++;
    if (int'(occupancy) !== ref_q.size()) begin
      n_bad++; $display("FAIL occupancy op=%0d: got %0d want %0d", op, occupancy, ref_q.size());
    end
    n_cmp++;
    if (n_push - p0 !== g.npush || n_pop - q0 !== g.npop) begin
      n_bad++; $display("FAIL strobes op=%0d: got push=%0d pop=%0d want push=%0d pop=%0d",
                        op, n_push - p0, n_pop - q0, g.npush, g.npop);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0 ||
        stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_din !== '0 || occupancy !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h e=%b push=%b pop=%b din=%h occ=%0d want rdy=1 rest 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_din, occupancy);
    end
    rst = 1'b0;
  endtask

  task automatic test_lifo();
    do_cmd(2'b00, 8'h11, 0); do_cmd(2'b00, 8'h22, 0); do_cmd(2'b00, 8'h33, 0);
    repeat (3) do_cmd(2'b01, 8'h00, 0);
  endtask

  task automatic test_underflow();
    do_cmd(2'b01, 8'hEE, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cmd(2'b00, WIDTH'(8'h40 + 3 * i), 0);
    do_cmd(2'b00, 8'hFF, 0);
    do_cmd(2'b01, 8'h00, 0);
  endtask

  task automatic test_swap();
    do_reset();
    do_cmd(2'b00, 8'hA1, 0); do_cmd(2'b00, 8'hB2, 0);
    do_cmd(2'b11, 8'h00, 0);
    do_cmd(2'b01, 8'h00, 0); do_cmd(2'b01, 8'h00, 0);
  endtask

  task automatic test_dup();
    do_reset();
    do_cmd(2'b00, 8'h5C, 0);
    do_cmd(2'b10, 8'h00, 0);
    do_cmd(2'b01, 8'h00, 0); do_cmd(2'b01, 8'h00, 0);
  endtask

  task automatic test_hold();
    do_reset();
    do_cmd(2'b00, 8'h77, 0);
    do_cmd(2'b01, 8'h00, 5);
  endtask

  task automatic test_reset_mid_swap();
    do_reset();
    do_cmd(2'b00, 8'hC3, 0); do_cmd(2'b00, 8'h3C, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0 ||
        stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_din !== '0 || occupancy !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_state: got rdy=%b v=%b d=%h e=%b push=%b pop=%b din=%h occ=%0d want rdy=1 rest 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_din, occupancy);
    end
    rst = 1'b0;
    ref_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_no_rsp: got v=%b want 0", rsp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (40) do_cmd(2'($urandom_range(0, 3)), WIDTH'($urandom), 0);
    n_cmp++;
    if (n_both !== 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_underflow();
    test_overflow();
    test_swap();
    test_dup();
    test_hold();
    test_reset_mid_swap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
